branch_hazard_unit: RTL and testbench

Execute-stage control block that produces the PC-redirect and stall controls consumed by the fetch PC register: `PCSrc`, `branch_target`, `jalr_target` and `Stall`. It holds the ID/EX control pipeline register for control-flow instructions. It resolves branches and jumps in EX with static predict-not-taken, detects load-use hazards, and generates the IF/ID flush and the EX bubble. Operand forwarding is outside this block: forwarded operand values arrive on `fwd_rs1_val`/`fwd_rs2_val` during EX.

---
 rtl/branch_hazard_unit.sv | 136 +++++++++++++
 tb/tb_branch_hazard_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: execute-stage control for control-flow instructions.
// Holds the ID/EX control register, resolves branches/jumps in EX with
// static predict-not-taken, detects load-use hazards and produces the
// PC-redirect, stall, IF/ID flush and EX bubble controls.
//
// There is no handshake here: ID presents an instruction every cycle
// (qualified by id_valid), and the EX register samples it on every rising
// edge. Only ex_valid is gated by a bubble; the other EX fields always load
// from ID and are meaningless whenever ex_valid is low.
module branch_hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [2:0]  id_funct3,
  input  logic        id_is_branch,
  input  logic        id_is_jal,
  input  logic        id_is_jalr,
  input  logic        id_is_load,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [31:0] fwd_rs1_val,
  input  logic [31:0] fwd_rs2_val,
  output logic [1:0]  PCSrc,
  output logic [31:0] branch_target,
  output logic [31:0] jalr_target,
  output logic        Stall,
  output logic        flush_if_id,
  output logic        ex_valid,
  output logic [31:0] ex_link,
  output logic [31:0] redirect_count
);

  // Branch condition codes (funct3).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  // EX-stage register contents.
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [2:0]  ex_funct3;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_is_load;
  logic [4:0]  ex_rd;

  // Resolution and hazard terms.
  logic cond;
  logic take;
  logic load_use;
  logic bubble;
  logic rd_hits_id;

  // Branch condition evaluated on the forwarded operands.
  always_comb begin
    cond = 1'b0;
    unique case (ex_funct3)
      F3_BEQ:  cond = (fwd_rs1_val == fwd_rs2_val);
      F3_BNE:  cond = (fwd_rs1_val != fwd_rs2_val);
      F3_BLT:  cond = ($signed(fwd_rs1_val) <  $signed(fwd_rs2_val));
      F3_BGE:  cond = ($signed(fwd_rs1_val) >= $signed(fwd_rs2_val));
      F3_BLTU: cond = (fwd_rs1_val <  fwd_rs2_val);
      F3_BGEU: cond = (fwd_rs1_val >= fwd_rs2_val);
      default: cond = 1'b0;  // 010/011 are never taken
    endcase
  end

  // Redirect decision and load-use detection (conservative on rs2).
  always_comb begin
    take       = ex_valid & ((ex_is_branch & cond) | ex_is_jal | ex_is_jalr);
    rd_hits_id = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    load_use   = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid & rd_hits_id;
    // A redirect squashes ID anyway, so either cause yields the same bubble.
    bubble     = take | load_use;
  end

  // PC-redirect, stall and flush controls; Stall is masked by a redirect so
  // the PC register never ignores a target.
  always_comb begin
    PCSrc = PCSRC_SEQ;
    if (take) begin
      PCSrc = ex_is_jalr ? PCSRC_JALR : PCSRC_BR;
    end
    Stall         = load_use & ~take;
    flush_if_id   = take;
    branch_target = ex_pc + ex_imm;
    jalr_target   = fwd_rs1_val + ex_imm;
    ex_link       = ex_pc + 32'd4;
  end

  // ID/EX register: fields follow ID every edge, ex_valid drops on a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= 32'd0;
      ex_imm       <= 32'd0;
      ex_funct3    <= 3'd0;
      ex_is_branch <= 1'b0;
      ex_is_jal    <= 1'b0;
      ex_is_jalr   <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rd        <= 5'd0;
    end else begin
      ex_valid     <= id_valid & ~bubble;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_funct3    <= id_funct3;
      ex_is_branch <= id_is_branch;
      ex_is_jal    <= id_is_jal;
      ex_is_jalr   <= id_is_jalr;
      ex_is_load   <= id_is_load;
      ex_rd        <= id_rd;
    end
  end

  // Count of taken redirects; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_count <= 32'd0;
    end else if (take) begin
      redirect_count <= redirect_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed and randomized bench for branch_hazard_unit with a behavioural
// model of the EX slot and the redirect/stall rules.
module tb_branch_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [2:0]  id_funct3;
  logic        id_is_branch;
  logic        id_is_jal;
  logic        id_is_jalr;
  logic        id_is_load;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] fwd_rs1_val;
  logic [31:0] fwd_rs2_val;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        Stall;
  logic        flush_if_id;
  logic        ex_valid;
  logic [31:0] ex_link;
  logic [31:0] redirect_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the instruction sitting in EX.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_imm;
  logic [2:0]  m_f3;
  logic        m_br, m_jal, m_jalr, m_ld;
  logic [4:0]  m_rd;
  logic [31:0] m_count;

  branch_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_funct3(id_funct3), .id_is_branch(id_is_branch), .id_is_jal(id_is_jal),
    .id_is_jalr(id_is_jalr), .id_is_load(id_is_load), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .fwd_rs1_val(fwd_rs1_val),
    .fwd_rs2_val(fwd_rs2_val), .PCSrc(PCSrc), .branch_target(branch_target),
    .jalr_target(jalr_target), .Stall(Stall), .flush_if_id(flush_if_id),
    .ex_valid(ex_valid), .ex_link(ex_link), .redirect_count(redirect_count)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return {1'b0, a} < {1'b0, b};
      3'd7:    return {1'b0, a} >= {1'b0, b};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_take();
    if (!m_valid) return 1'b0;
    if (m_jal || m_jalr) return 1'b1;
    return m_br && m_cond(m_f3, fwd_rs1_val, fwd_rs2_val);
  endfunction

  function automatic logic m_lu();
    return m_valid && m_ld && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_imm = 0; m_f3 = 0;
    m_br = 0; m_jal = 0; m_jalr = 0; m_ld = 0; m_rd = 0; m_count = 0;
  endtask

  task automatic check_all();
    logic t, lu;
    logic [1:0] exp_src;
    t  = m_take();
    lu = m_lu();
    exp_src = !t ? 2'd0 : (m_jalr ? 2'd2 : 2'd1);
    check("pcsrc",         {30'd0, PCSrc},   {30'd0, exp_src});
    check("stall",         {31'd0, Stall},   {31'd0, lu && !t});
    check("flush",         {31'd0, flush_if_id}, {31'd0, t});
    check("ex_valid",      {31'd0, ex_valid}, {31'd0, m_valid});
    check("branch_target", branch_target, m_pc + m_imm);
    check("jalr_target",   jalr_target, fwd_rs1_val + m_imm);
    check("ex_link",       ex_link, m_pc + 32'd4);
    check("redirect_count", redirect_count, m_count);
  endtask

  // Advance one clock: model follows the edge, then return to the negedge.
  task automatic tick();
    logic t, lu;
    @(posedge clk);
    t  = m_take();
    lu = m_lu();
    if (rst) begin
      model_reset();
    end else begin
      if (t) m_count = m_count + 1;
      m_valid = id_valid && !(t || lu);
      m_pc = id_pc; m_imm = id_imm; m_f3 = id_funct3;
      m_br = id_is_branch; m_jal = id_is_jal; m_jalr = id_is_jalr;
      m_ld = id_is_load; m_rd = id_rd;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [2:0] f3, input logic br, input logic jal,
                       input logic jalr, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] a, input logic [31:0] b);
    id_valid = v; id_pc = pc; id_imm = imm; id_funct3 = f3;
    id_is_branch = br; id_is_jal = jal; id_is_jalr = jalr; id_is_load = ld;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    fwd_rs1_val = a; fwd_rs2_val = b;
  endtask

  // Plain ALU-type instruction with registers that never collide with rd=3.
  task automatic drive_nop(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    drive(1, pc, 32'd0, 3'd0, 0, 0, 0, 0, 5'd9, 5'd10, 5'd11, a, b);
  endtask

  // Load a branch into EX, then resolve it with operands a/b.
  task automatic branch_case(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic exp_take);
    drive(1, 32'h100, 32'h20, f3, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive_nop(32'h104, a, b);
    #1 check_all();
    check(tag, {30'd0, PCSrc}, exp_take ? 32'd1 : 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 32'd0, 32'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h1234_5678, 32'd0);
    model_reset();
    @(negedge clk);
    #1 check_all();
    check("rst_ex_link", ex_link, 32'd4);
    check("rst_jalr_follows", jalr_target, 32'h1234_5678);
    rst = 1'b0;
    @(negedge clk);

    // BEQ taken, then bubble and count.
    drive(1, 32'h100, 32'h20, 3'd0, 1, 0, 0, 0, 5'd0, 5'd5, 5'd6, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive_nop(32'h104, 32'd5, 32'd5);
    #1 check_all();
    check("beq_pcsrc", {30'd0, PCSrc}, 32'd1);
    check("beq_target", branch_target, 32'h120);
    check("beq_flush", {31'd0, flush_if_id}, 32'd1);
    tick();
    drive_nop(32'h108, 32'd0, 32'd0);
    #1 check_all();
    check("beq_bubble", {31'd0, ex_valid}, 32'd0);
    check("beq_count", redirect_count, 32'd1);
    tick();

    branch_case("beq_not_taken", 3'd0, 32'd5, 32'd6, 0);
    branch_case("blt_signed",    3'd4, 32'hFFFF_FFFF, 32'd1, 1);
    branch_case("bltu_unsigned", 3'd6, 32'hFFFF_FFFF, 32'd1, 0);
    branch_case("bgeu_unsigned", 3'd7, 32'hFFFF_FFFF, 32'd1, 1);
    branch_case("f3_010_never",  3'd2, 32'd7, 32'd7, 0);
    branch_case("bne_taken",     3'd1, 32'd7, 32'd8, 1);
    branch_case("bge_signed",    3'd5, 32'h8000_0000, 32'd0, 0);

    // JALR with normal and wrapping immediates.
    drive(1, 32'h300, 32'd4, 3'd0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive_nop(32'h304, 32'h2001, 32'd0);
    #1 check_all();
    check("jalr_pcsrc", {30'd0, PCSrc}, 32'd2);
    check("jalr_target", jalr_target, 32'h2005);
    check("jalr_link", ex_link, 32'h304);
    tick();
    drive(1, 32'h400, 32'hFFFF_FFFC, 3'd0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive_nop(32'h404, 32'd0, 32'd0);
    #1 check_all();
    check("jalr_wrap", jalr_target, 32'hFFFF_FFFC);
    tick();

    // Load-use: exactly one stall cycle, then ID proceeds.
    drive(1, 32'h500, 32'd0, 3'd2, 0, 0, 0, 1, 5'd3, 5'd1, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive(1, 32'h504, 32'd0, 3'd0, 0, 0, 0, 0, 5'd4, 5'd7, 5'd3, 32'd0, 32'd0);
    #1 check_all();
    check("lu_stall", {31'd0, Stall}, 32'd1);
    tick();
    #1 check_all();
    check("lu_stall_drop", {31'd0, Stall}, 32'd0);
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    #1 check_all();
    check("lu_proceed", {31'd0, ex_valid}, 32'd1);
    tick();
    // Load to x0 never stalls.
    drive(1, 32'h600, 32'd0, 3'd2, 0, 0, 0, 1, 5'd0, 5'd1, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive(1, 32'h604, 32'd0, 3'd0, 0, 0, 0, 0, 5'd4, 5'd0, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    check("lu_rd0", {31'd0, Stall}, 32'd0);
    tick();

    // Collision: JAL with load_use forced true through the load flag.
    drive(1, 32'h700, 32'h40, 3'd0, 0, 1, 0, 1, 5'd3, 5'd1, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    tick();
    drive(1, 32'h704, 32'd0, 3'd0, 0, 0, 0, 0, 5'd4, 5'd3, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    check("coll_stall", {31'd0, Stall}, 32'd0);
    check("coll_pcsrc", {30'd0, PCSrc}, 32'd1);
    check("coll_flush", {31'd0, flush_if_id}, 32'd1);
    tick();
    #1 check_all();
    check("coll_bubble", {31'd0, ex_valid}, 32'd0);
    tick();

    // Asynchronous reset mid-cycle while EX holds a taken JAL.
    drive(1, 32'h800, 32'h10, 3'd0, 0, 1, 0, 0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0);
    #1 check_all();
    tick();
    #1 check_all();
    check("arst_pre_pcsrc", {30'd0, PCSrc}, 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("arst_pcsrc", {30'd0, PCSrc}, 32'd0);
    check("arst_flush", {31'd0, flush_if_id}, 32'd0);
    check("arst_count", redirect_count, 32'd0);
    check_all();
    tick();
    rst = 1'b0;

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      int cls;
      logic [31:0] a, b;
      cls = $urandom_range(0, 4);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      drive($urandom_range(0, 7) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)),
            cls == 1, cls == 2, cls == 3, cls == 4,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            a, b);
      #1 check_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
